// File: rtl/m_seq_gen.sv
// Free-running Fibonacci LFSR producing a maximal-length pseudo-random bit stream.
// One chip per clock on m; period_start flags the cycle in which state equals SEED.
module m_seq_gen #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             m,
  output logic [WIDTH-1:0] state,
  output logic             period_start
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("m_seq_gen: WIDTH must be at least 2");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("m_seq_gen: SEED must be non-zero");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("m_seq_gen: TAPS must include the top state bit");
    end
  endgenerate

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] next_state;
  logic             fb;
  logic             period_start_q;

  // The all-zero state is a fixed point of any XOR feedback; steer it back to SEED.
  always_comb begin
    fb         = ^(state_q & TAPS);
    next_state = {state_q[WIDTH-2:0], fb};
    if (state_q == '0) begin
      next_state = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= SEED;
      period_start_q <= 1'b1;
    end else begin
      state_q        <= next_state;
      period_start_q <= (next_state == SEED);
    end
  end

  assign state        = state_q;
  assign m            = state_q[WIDTH-1];
  assign period_start = period_start_q;

endmodule

// File: tb/tb_m_seq_gen.sv
// Bench for m_seq_gen: checks reset, the documented chip sequence, period statistics,
// mid-run reset, lock-up recovery and a WIDTH=7 instance against a bit-stream recurrence model.
module tb_m_seq_gen;

  localparam int         W     = 4;
  localparam logic [3:0] TAPS4 = 4'b1100;
  localparam logic [3:0] SEED4 = 4'b0001;

  // clock / reset
  logic clk;
  logic rstn;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  logic         m;
  logic [W-1:0] state;
  logic         period_start;

  logic         m7;
  logic [6:0]   state7;
  logic         period_start7;

  m_seq_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m            (m),
    .state        (state),
    .period_start (period_start)
  );

  m_seq_gen #(.WIDTH(7), .TAPS(7'b1100000), .SEED(7'd1)) dut7 (
    .clk          (clk),
    .rstn         (rstn),
    .m            (m7),
    .state        (state7),
    .period_start (period_start7)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the chip stream as a recurrence b[t+1] = XOR of taps over recent bits.
  // bits_q back = newest bit; state bit i corresponds to the bit i steps old.
  bit bits_q[$];

  task automatic model_reset();
    bits_q.delete();
    for (int i = W - 1; i >= 0; i--) bits_q.push_back(SEED4[i]);
  endtask

  task automatic model_step();
    bit nb;
    int sz;
    nb = 1'b0;
    sz = bits_q.size();
    for (int i = 0; i < W; i++) begin
      if (TAPS4[i]) nb ^= bits_q[sz-1-i];
    end
    bits_q.push_back(nb);
    void'(bits_q.pop_front());
  endtask

  function automatic logic [W-1:0] model_state();
    logic [W-1:0] v;
    int sz;
    sz = bits_q.size();
    for (int i = 0; i < W; i++) v[i] = bits_q[sz-1-i];
    return v;
  endfunction

  // driver: apply rstn for one edge, update the model, compare all outputs
  task automatic cycle(input logic r);
    logic [W-1:0] es;
    rstn = r;
    @(posedge clk);
    #1;
    if (!r) model_reset();
    else    model_step();
    es = model_state();
    check("state", 32'(state), 32'(es));
    check("m", 32'(m), 32'(es[W-1]));
    check("period_start", 32'(period_start), 32'(es == SEED4));
  endtask

  logic [3:0] table_state [15];
  int ones, ps_cnt, first_ret;

  initial begin
    table_state = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                    4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
                    4'b0001};
    rstn = 1'b0;
    model_reset();

    // reset held for 1000 ns
    repeat (50) cycle(1'b0);
    check("reset_state", 32'(state), 32'(SEED4));
    check("reset_m", 32'(m), 32'd0);

    // documented first period
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1);
      check("table_state", 32'(state), 32'(table_state[k]));
      check("table_m", 32'(m), 32'(table_state[k][3]));
    end

    // three more periods: cadence, balance, no zero state
    for (int p = 0; p < 3; p++) begin
      ones   = 0;
      ps_cnt = 0;
      for (int k = 0; k < 15; k++) begin
        cycle(1'b1);
        if (m) ones++;
        if (period_start) ps_cnt++;
        check("state_nonzero", 32'(state == '0), 32'd0);
      end
      check("period_ones", 32'(ones), 32'd8);
      check("period_starts", 32'(ps_cnt), 32'd1);
      check("period_end_state", 32'(state), 32'(SEED4));
    end

    // mid-run reset at cycle 7
    repeat (7) cycle(1'b1);
    cycle(1'b0);
    check("midreset_state", 32'(state), 32'(SEED4));
    cycle(1'b1);
    check("restart_chip0", 32'(m), 32'd0);
    cycle(1'b1);
    check("restart_chip1", 32'(m), 32'd0);
    cycle(1'b1);
    check("restart_chip2", 32'(m), 32'd1);

    // lock-up: zero state must steer back to SEED
    force dut.state_q = 4'b0000;
    #1;
    check("lockup_next", 32'(dut.next_state), 32'(SEED4));
    release dut.state_q;
    cycle(1'b0);
    check("lockup_recover", 32'(state), 32'(SEED4));

    // randomized run with occasional reset pulses
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1);
    end

    // WIDTH=7 instance: full period from reset
    cycle(1'b0);
    cycle(1'b0);
    check("w7_reset_state", 32'(state7), 32'd1);
    ones      = 0;
    ps_cnt    = 0;
    first_ret = 0;
    for (int k = 1; k <= 127; k++) begin
      cycle(1'b1);
      if (m7) ones++;
      if (period_start7) ps_cnt++;
      if (state7 == 7'd1 && first_ret == 0) first_ret = k;
    end
    check("w7_period", 32'(first_ret), 32'd127);
    check("w7_ones", 32'(ones), 32'd64);
    check("w7_period_starts", 32'(ps_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
